// File: rtl/d_hazard_if.sv
// D-stage hazard interface: decoded D-stage operand/producer info in,
// stall, forwarding selects and the stall counter out.
interface d_hazard_if #(
  parameter int CNT_W = 16
);
  logic             d_valid;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic [1:0]       d_tuse_rs;
  logic [1:0]       d_tuse_rt;
  logic [4:0]       d_dst;
  logic [1:0]       d_tnew;
  logic             stall;
  logic [1:0]       fwd_sel_rs;
  logic [1:0]       fwd_sel_rt;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    input  stall, fwd_sel_rs, fwd_sel_rt, stall_count
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    output stall, fwd_sel_rs, fwd_sel_rt, stall_count
  );
endinterface

// File: rtl/d_hazard_unit.sv
// D-stage hazard/forwarding controller: shadows E/M/W destination and Tnew,
// derives stall and comparator forwarding selects, counts stall cycles.

module d_hazard_opnd (
  input  logic       valid_i,
  input  logic [4:0] reg_i,
  input  logic [1:0] tuse_i,
  input  logic [4:0] e_dst_i,
  input  logic [1:0] e_tnew_i,
  input  logic [4:0] m_dst_i,
  input  logic [1:0] m_tnew_i,
  input  logic [4:0] w_dst_i,
  output logic       stall_o,
  output logic [1:0] fwd_sel_o
);
  logic rd_en, e_hit, m_hit, w_hit;

  always_comb begin
    rd_en   = valid_i && (reg_i != 5'd0);
    e_hit   = rd_en && (reg_i == e_dst_i);
    m_hit   = rd_en && (reg_i == m_dst_i);
    w_hit   = rd_en && (reg_i == w_dst_i);
    stall_o = (e_hit && (e_tnew_i > tuse_i)) || (m_hit && (m_tnew_i > tuse_i));
    // Youngest match owns the operand; an unready young match blocks older stages.
    fwd_sel_o = 2'd0;
    if (e_hit) begin
      if (e_tnew_i == 2'd0) fwd_sel_o = 2'd1;
    end else if (m_hit) begin
      if (m_tnew_i == 2'd0) fwd_sel_o = 2'd2;
    end else if (w_hit) begin
      fwd_sel_o = 2'd3;
    end
  end
endmodule

module d_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  d_hazard_if.slave hz
);
  localparam int NUM_OPND = 2;

  logic [4:0]       e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
  logic [1:0]       e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_OPND-1:0][4:0] rd_reg;
  logic [NUM_OPND-1:0][1:0] rd_tuse;
  logic [NUM_OPND-1:0]      opnd_stall;
  logic [NUM_OPND-1:0][1:0] opnd_sel;
  logic                     stall;

  // Lane 0 is rs (comparator A), lane 1 is rt (comparator B).
  assign rd_reg  = {hz.d_rt, hz.d_rs};
  assign rd_tuse = {hz.d_tuse_rt, hz.d_tuse_rs};

  for (genvar g = 0; g < NUM_OPND; g++) begin : g_opnd
    d_hazard_opnd u_opnd (
      .valid_i   (hz.d_valid),
      .reg_i     (rd_reg[g]),
      .tuse_i    (rd_tuse[g]),
      .e_dst_i   (e_dst_q),
      .e_tnew_i  (e_tnew_q),
      .m_dst_i   (m_dst_q),
      .m_tnew_i  (m_tnew_q),
      .w_dst_i   (w_dst_q),
      .stall_o   (opnd_stall[g]),
      .fwd_sel_o (opnd_sel[g])
    );
  end

  assign stall          = |opnd_stall;
  assign hz.stall       = stall;
  assign hz.fwd_sel_rs  = opnd_sel[0];
  assign hz.fwd_sel_rt  = opnd_sel[1];
  assign hz.stall_count = cnt_q;

  always_comb begin
    e_dst_d  = 5'd0;
    e_tnew_d = 2'd0;
    if (hz.d_valid && !stall) begin
      e_dst_d  = hz.d_dst;
      e_tnew_d = hz.d_tnew;
    end
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    w_dst_d  = m_dst_q;
    cnt_d    = cnt_q;
    if (stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      w_dst_q  <= '0;
      cnt_q    <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_d_hazard_unit.sv
// Bench for d_hazard_unit: directed hazard scenarios plus random traffic
// against a queue-based model of in-flight producers.
module tb_d_hazard_unit;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d_hazard_if #(.CNT_W(CW)) hz ();
  d_hazard_unit #(.CNT_W(CW)) dut (.clk(clk), .reset(rst_n), .hz(hz));

  typedef struct {
    int dst;
    int tnew;
  } prod_t;

  prod_t pq[$];   // index 0 = E, 1 = M, 2 = W; tnew as issued
  int cnt_m;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int eff(input int age);
    if (age >= 2) return 0;
    return (pq[age].tnew > age) ? pq[age].tnew - age : 0;
  endfunction

  function automatic void ref_opnd(input bit v, input int r, input int tuse,
                                   output bit st, output int sel);
    bit found;
    found = 0;
    st = 0;
    sel = 0;
    if (v && r != 0)
      for (int a = 0; a < 3; a++)
        if (pq[a].dst == r) begin
          if (a < 2 && eff(a) > tuse) st = 1;
          if (!found) begin
            found = 1;
            sel = (eff(a) == 0) ? a + 1 : 0;
          end
        end
  endfunction

  task automatic model_reset();
    pq.delete();
    repeat (3) pq.push_back('{0, 0});
    cnt_m = 0;
  endtask

  // One cycle: drive at negedge, check comb outputs, advance the model at posedge.
  task automatic cyc(input string tag, input bit v, input int rs, input int rt,
                     input int tur, input int tut, input int dst, input int tnew,
                     output bit st_o, output int srs_o, output int srt_o);
    bit s1, s2, st;
    int e1, e2;
    @(negedge clk);
    hz.d_valid = v;
    hz.d_rs = 5'(rs);
    hz.d_rt = 5'(rt);
    hz.d_tuse_rs = 2'(tur);
    hz.d_tuse_rt = 2'(tut);
    hz.d_dst = 5'(dst);
    hz.d_tnew = 2'(tnew);
    #1;
    ref_opnd(v, rs, tur, s1, e1);
    ref_opnd(v, rt, tut, s2, e2);
    st = s1 | s2;
    chk({tag, ".stall"}, hz.stall, int'(st));
    chk({tag, ".sel_rs"}, hz.fwd_sel_rs, e1);
    chk({tag, ".sel_rt"}, hz.fwd_sel_rt, e2);
    chk({tag, ".cnt"}, hz.stall_count, cnt_m);
    st_o = hz.stall;
    srs_o = int'(hz.fwd_sel_rs);
    srt_o = int'(hz.fwd_sel_rt);
    @(posedge clk);
    if (rst_n) begin
      if (st && cnt_m < CMAX) cnt_m++;
      if (v && !st) pq.push_front('{dst, tnew});
      else pq.push_front('{0, 0});
      void'(pq.pop_back());
    end
  endtask

  initial begin
    bit st;
    int a, b;
    model_reset();
    hz.d_valid = 0; hz.d_rs = 0; hz.d_rt = 0; hz.d_tuse_rs = 0;
    hz.d_tuse_rt = 0; hz.d_dst = 0; hz.d_tnew = 0;

    // In reset: producer then reader must show nothing
    cyc("inrst.p", 1, 0, 0, 0, 0, 7, 3, st, a, b);
    cyc("inrst.r", 1, 7, 7, 0, 0, 0, 0, st, a, b);
    chk("inrst.stall", st, 0);
    @(negedge clk); rst_n = 1;

    cyc("rst", 1, 5, 6, 0, 0, 0, 0, st, a, b);
    chk("rst.stall", st, 0); chk("rst.sel_rs", a, 0); chk("rst.sel_rt", b, 0);

    // Load-then-branch on $8
    cyc("ld.p", 1, 0, 0, 3, 3, 8, 2, st, a, b);
    cyc("ld.r2", 1, 8, 0, 0, 3, 0, 0, st, a, b); chk("ld.c2.stall", st, 1);
    cyc("ld.r3", 1, 8, 0, 0, 3, 0, 0, st, a, b); chk("ld.c3.stall", st, 1);
    cyc("ld.r4", 1, 8, 0, 0, 3, 0, 0, st, a, b);
    chk("ld.c4.stall", st, 0); chk("ld.c4.sel_rs", a, 3);
    chk("ld.cnt", hz.stall_count, 2);

    repeat (3) cyc("fl", 0, 0, 0, 0, 0, 0, 0, st, a, b);
    // ALU then beq $9,$9
    cyc("alu.p", 1, 0, 0, 3, 3, 9, 1, st, a, b);
    cyc("alu.r1", 1, 9, 9, 0, 0, 0, 0, st, a, b); chk("alu.c1.stall", st, 1);
    cyc("alu.r2", 1, 9, 9, 0, 0, 0, 0, st, a, b);
    chk("alu.c2.stall", st, 0); chk("alu.sel_rs", a, 2); chk("alu.sel_rt", b, 2);
    chk("alu.cnt", hz.stall_count, 3);

    repeat (3) cyc("fl", 0, 0, 0, 0, 0, 0, 0, st, a, b);
    // Priority: E beats M
    cyc("pri.p1", 1, 0, 0, 3, 3, 10, 0, st, a, b);
    cyc("pri.p2", 1, 0, 0, 3, 3, 10, 0, st, a, b);
    cyc("pri.r", 1, 10, 0, 0, 3, 0, 0, st, a, b);
    chk("pri.sel_rs", a, 1); chk("pri.stall", st, 0);

    repeat (3) cyc("fl", 0, 0, 0, 0, 0, 0, 0, st, a, b);
    // $0 and bubbles
    cyc("z.p", 1, 0, 0, 3, 3, 0, 2, st, a, b);
    cyc("z.r", 1, 0, 0, 0, 0, 0, 0, st, a, b);
    chk("z.stall", st, 0); chk("z.sel_rs", a, 0);
    cyc("bub.p", 0, 0, 0, 3, 3, 11, 3, st, a, b);
    for (int i = 0; i < 3; i++) begin
      cyc("bub.r", 1, 11, 11, 0, 0, 0, 0, st, a, b);
      chk("bub.stall", st, 0); chk("bub.sel_rs", a, 0); chk("bub.sel_rt", b, 0);
    end

    repeat (3) cyc("fl", 0, 0, 0, 0, 0, 0, 0, st, a, b);
    // Reset mid-stall
    cyc("mr.p", 1, 0, 0, 3, 3, 12, 3, st, a, b);
    cyc("mr.r", 1, 12, 0, 0, 3, 0, 0, st, a, b); chk("mr.pre.stall", st, 1);
    @(negedge clk); #1;
    chk("mr.hold.stall", hz.stall, 1);
    rst_n = 0; #1;
    chk("mr.stall", hz.stall, 0);
    chk("mr.cnt", hz.stall_count, 0);
    chk("mr.sel_rs", hz.fwd_sel_rs, 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    cyc("mr.after", 1, 12, 0, 0, 3, 0, 0, st, a, b);
    chk("mr.after.stall", st, 0);

    // Random traffic, includes counter saturation
    for (int i = 0; i < 3000; i++)
      cyc("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), st, a, b);
    chk("sat.cnt", hz.stall_count, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
